// File: rtl/mips_pkg.sv
// Shared MIPS fetch-side constants: opcodes, sequencer states, default vectors.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] FUNCT_JR = 6'h08;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0040_0000;
  localparam logic [31:0] DEF_EXC_VEC   = 32'h8000_0180;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } seq_state_e;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational next-PC select for J/JAL, BEQ/BNE, JR and sequential flow.
// Zero latency, no flow control; caller decides whether the result is taken.
module pc_target_calc
  import mips_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [31:0]       inst_i,
  input  logic              regs_equal_i,
  input  logic [ADDR_W-1:0] jr_target_i,
  output logic [ADDR_W-1:0] next_pc_o,
  output logic              is_jal_o,
  output logic              jr_misaligned_o
);

  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] jump_tgt;
  logic [ADDR_W-1:0] br_off;
  logic [ADDR_W-1:0] br_tgt;
  logic              is_jr;

  assign opcode   = inst_i[31:26];
  assign funct    = inst_i[5:0];
  assign pc_plus4 = pc_i + ADDR_W'(4);

  // Jump region comes from the incremented PC, so a J in the last slot of a region lands in the next one.
  assign jump_tgt = {pc_plus4[ADDR_W-1:28], inst_i[25:0], 2'b00};
  assign br_off   = {{(ADDR_W-18){inst_i[15]}}, inst_i[15:0], 2'b00};
  assign br_tgt   = pc_plus4 + br_off;

  assign is_jr           = (opcode == OP_RTYPE) && (funct == FUNCT_JR);
  assign is_jal_o        = (opcode == OP_JAL);
  assign jr_misaligned_o = is_jr && (jr_target_i[1:0] != 2'b00);

  always_comb begin
    next_pc_o = pc_plus4;
    case (opcode)
      OP_J, OP_JAL: next_pc_o = jump_tgt;
      OP_BEQ:       if (regs_equal_i)  next_pc_o = br_tgt;
      OP_BNE:       if (!regs_equal_i) next_pc_o = br_tgt;
      OP_RTYPE:     if (is_jr)         next_pc_o = jr_target_i;
      default:      next_pc_o = pc_plus4;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter unit: RUN/HALT FSM, PC, EPC and saturating retire counter.
// Redirects take effect one clock after acceptance; stall holds all state.
module pc_sequencer
  import mips_pkg::*;
#(
  parameter int          ADDR_W    = 32,
  parameter logic [31:0] RESET_VEC = DEF_RESET_VEC,
  parameter logic [31:0] EXC_VEC   = DEF_EXC_VEC,
  parameter int          CNT_W     = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              inst_valid,
  input  logic [31:0]       inst,
  input  logic              regs_equal,
  input  logic [ADDR_W-1:0] jr_target,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [ADDR_W-1:0] link_addr,
  output logic              is_jal,
  output logic              halted,
  output logic              exc_pulse,
  output logic [ADDR_W-1:0] epc,
  output logic [CNT_W-1:0]  retired
);

  localparam logic [ADDR_W-1:0] RST_PC = RESET_VEC[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] EXC_PC = EXC_VEC[ADDR_W-1:0];

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] epc_q, epc_d;
  logic              exc_q, exc_d;
  logic [CNT_W-1:0]  retired_q, retired_d;

  logic [ADDR_W-1:0] next_pc;
  logic              jr_misaligned;
  logic              fetch_ok;
  logic              accept;
  logic              halt_req;

  pc_target_calc #(
    .ADDR_W(ADDR_W)
  ) u_target (
    .pc_i           (pc_q),
    .inst_i         (inst),
    .regs_equal_i   (regs_equal),
    .jr_target_i    (jr_target),
    .next_pc_o      (next_pc),
    .is_jal_o       (is_jal),
    .jr_misaligned_o(jr_misaligned)
  );

  // Stall masks both halt detection and the exception path.
  assign fetch_ok = (state_q == RUN) && !stall && inst_valid;
  assign accept   = fetch_ok && (inst != 32'd0);
  assign halt_req = fetch_ok && (inst == 32'd0);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    epc_d     = epc_q;
    exc_d     = 1'b0;
    retired_d = retired_q;

    if (halt_req) begin
      state_d = HALT;
    end

    if (accept) begin
      if (retired_q != {CNT_W{1'b1}}) begin
        retired_d = retired_q + CNT_W'(1);
      end
      if (jr_misaligned) begin
        pc_d  = EXC_PC;
        epc_d = pc_q;
        exc_d = 1'b1;
      end else begin
        pc_d = next_pc;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= RUN;
      pc_q      <= RST_PC;
      epc_q     <= '0;
      exc_q     <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      epc_q     <= epc_d;
      exc_q     <= exc_d;
      retired_q <= retired_d;
    end
  end

  assign pc        = pc_q;
  assign pc_plus4  = pc_q + ADDR_W'(4);
  assign link_addr = pc_q + ADDR_W'(8);
  assign halted    = (state_q == HALT);
  assign exc_pulse = exc_q;
  assign epc       = epc_q;
  assign retired   = retired_q;

endmodule
